// File: rtl/wiphase_dbg_cmd_queue.sv
// Debug command queue: captures {ir_in, sr} on each synchronized update-DR edge, strobes update-IR edges.
// Latency: SYNC_STAGES+1 clk from vs_udr/vs_uir rising to cmd_valid/uir_pulse; show-ahead head output.
// Backpressure: cmd_ready pops the head; a push into a full queue with no same-cycle pop is dropped and sets overflow.
module wiphase_dbg_cmd_queue #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [IR_W-1:0]                 ir_in,
    input  logic [DATA_W-1:0]               sr,
    input  logic                            vs_udr,
    input  logic                            vs_uir,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic [IR_W-1:0]                 cmd_ir,
    output logic [DATA_W-1:0]               cmd_data,
    output logic                            uir_pulse,
    output logic                            overflow,
    input  logic                            ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]     level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENT_W   = IR_W + DATA_W;
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);
    localparam logic [LVL_W-1:0]   FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [FLUSH_W-1:0] FLUSH_END = FLUSH_W'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_hist;
    logic                   uir_hist;
    logic                   udr_armed;
    logic                   uir_armed;
    logic [FLUSH_W-1:0]     flush_cnt;
    logic                   flush_done;
    logic                   udr_lvl;
    logic                   uir_lvl;
    logic                   push;
    logic                   uir_rise;

    logic [ENT_W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [ENT_W-1:0]       head;
    logic                   full;
    logic                   pop;
    logic                   wr_en;
    logic                   drop;

    assign udr_lvl    = udr_sync[SYNC_STAGES-1];
    assign uir_lvl    = uir_sync[SYNC_STAGES-1];
    assign flush_done = (flush_cnt == FLUSH_END);

    // Edges only count once the chain has flushed post-reset and the level was seen low,
    // so a strobe held high across reset release is not mistaken for a new update.
    assign push     = udr_armed & udr_lvl & ~udr_hist;
    assign uir_rise = uir_armed & uir_lvl & ~uir_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync  <= '0;
            uir_sync  <= '0;
            udr_hist  <= 1'b0;
            uir_hist  <= 1'b0;
            udr_armed <= 1'b0;
            uir_armed <= 1'b0;
            flush_cnt <= '0;
            uir_pulse <= 1'b0;
        end else begin
            udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_hist  <= udr_lvl;
            uir_hist  <= uir_lvl;
            uir_pulse <= uir_rise;
            if (!flush_done) begin
                flush_cnt <= flush_cnt + FLUSH_W'(1);
            end
            if (flush_done && !udr_lvl) begin
                udr_armed <= 1'b1;
            end
            if (flush_done && !uir_lvl) begin
                uir_armed <= 1'b1;
            end
        end
    end

    assign cmd_valid = (level != '0);
    assign full      = (level == FULL_LVL);
    assign pop       = cmd_valid & cmd_ready;
    // A pop in the same cycle frees the slot the push needs, even when full.
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;

    assign head     = mem[rd_ptr];
    assign cmd_ir   = cmd_valid ? head[ENT_W-1 -: IR_W] : '0;
    assign cmd_data = cmd_valid ? head[DATA_W-1:0]      : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {ir_in, sr};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
